projectile_pool_fsm: RTL and testbench
======================================

Name: projectile_pool_fsm

Overview:
- Generalised successor to the single-projectile shot FSM.
- Manages a pool of NUM_SLOTS independent projectile slots shared by player and enemy shooters.
- Each slot runs its own load/flight state machine. Each new shot request goes to a free slot by fixed priority. A per-frame player cooldown and a cap on enemy projectiles in flight limit the firing rate.
- Sits between shooter control logic and the per-slot projectile movement/draw blocks.

Parameters:
- NUM_SLOTS, 4: number of projectile slots (2..8).
- MAX_ENEMY_IN_FLIGHT, 2: max slots simultaneously owned by the enemy, loading or flying (1..NUM_SLOTS).
- PLAYER_COOLDOWN_FRAMES, 6: frames after an accepted player shot during which player requests are refused (0 = no cooldown, max 15).
- ENEMY_PROJECTILE_BASE_SPEED, 130: enemy speed at level 0, positive = downwards.
- PLAYER_PROJECTILE_BASE_SPEED, 300: player speed magnitude, negative = upwards.
- LEVEL_SPEED_MODIFIER, 10: enemy speed added per level.
- PLAYER_PROJECTILE_POWERUP_SPEED, 200: extra player speed magnitude while speedPowerup=1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame (30Hz).
- shootRequestPlayer  in  1  one-cycle player fire request.
- shootRequestEnemy  in  1  one-cycle enemy fire request.
- projectileEnd  in  NUM_SLOTS  per-slot end of flight (collision/off-screen).
- level  in  4  current level 0..15.
- endLevel  in  1  level-end pulse; flushes pool.
- speedPowerup  in  1  player speed powerup active.
- visible  out  NUM_SLOTS  slot projectile drawn.
- loadCoordinates  out  NUM_SLOTS  one-cycle pulse: slot latches shooter coordinates.
- speed  out  NUM_SLOTS*12  packed signed 12-bit speed per slot; slot i at [12*i+11:12*i].
- beingShot  out  NUM_SLOTS  slot not idle.
- playerAccept  out  1  registered pulse: player request accepted.
- enemyAccept  out  1  registered pulse: enemy request accepted.
- shotDropped  out  1  registered pulse: a request was refused.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all slots IDLE, all outputs 0, cooldown counter 0, enemy count 0.
- Per-slot states: IDLE, LOAD_P, LOAD_E, FLY_P, FLY_E.
  - IDLE -> LOAD_P/LOAD_E on allocation.
  - LOAD_x -> FLY_x after exactly one cycle.
  - FLY_x -> IDLE when projectileEnd[i] or endLevel.
- Outputs are combinational from slot state:
  - loadCoordinates[i] = 1 in LOAD_x.
  - visible[i] = 1 in FLY_x.
  - beingShot[i] = 1 when not IDLE.
  - speed = 0 except in FLY_P: -(PLAYER_PROJECTILE_BASE_SPEED + PLAYER_PROJECTILE_POWERUP_SPEED*speedPowerup).
  - speed in FLY_E: ENEMY_PROJECTILE_BASE_SPEED + LEVEL_SPEED_MODIFIER*level.
  - Range is -500..+280 at defaults; 12-bit signed, no saturation.
- Allocation is evaluated in the request cycle; the slot enters LOAD in the next cycle.
  - Player takes the lowest-index IDLE slot.
  - Enemy takes the lowest-index IDLE slot not taken by the player in the same cycle.
  - Both requests in one cycle with two or more free slots: both accepted.
  - Exactly one free slot: player wins; enemy is refused.
- Player acceptance requires cooldown counter = 0 and a free slot. On acceptance, counter loads PLAYER_COOLDOWN_FRAMES.
- Cooldown counter decrements by 1 on startOfFrame when nonzero. If acceptance and startOfFrame coincide, the load wins.
- Enemy acceptance requires enemy count < MAX_ENEMY_IN_FLIGHT and a free slot. Enemy count = number of slots in LOAD_E or FLY_E.
- A slot freed in cycle t (projectileEnd) becomes allocatable at t+1, not in t.
- projectileEnd[i] while the slot is IDLE or LOAD_x is ignored.
- endLevel has top priority:
  - All slots go to IDLE next cycle and the cooldown clears.
  - Requests in the same cycle are refused without asserting shotDropped.
- playerAccept, enemyAccept and shotDropped are registered and appear one cycle after the request, aligned with loadCoordinates.

Optional Feature:
- Macro: PROJECTILE_PENDING_EN.
- When defined:
  - A refused request that was refused only for lack of a free slot sets a one-deep pending flag for that source instead of pulsing shotDropped.
  - A pending flag is served as a request on the first cycle a slot is free and the source's gating allows it. Player pending has priority over a new enemy request.
  - A second refusal while the flag is set pulses shotDropped.
  - endLevel clears both flags.
- When undefined: no pending storage; every refusal pulses shotDropped.

Test Plan:
- Reset, then player request -> next cycle loadCoordinates=0001, playerAccept=1. Following cycle visible[0]=1, speed[0]=-300; with speedPowerup=1, speed[0]=-500.
- Enemy request with level=15 while slot 0 is flying -> slot 1 loads, then speed[1]=+280. projectileEnd[1] -> next cycle beingShot[1]=0.
- Player requests on consecutive frames with PLAYER_COOLDOWN_FRAMES=6 -> second request refused (shotDropped=1). Request accepted again after 6 startOfFrame pulses.
- Three enemy requests with all slots free and MAX_ENEMY_IN_FLIGHT=2 -> slots 0 and 1 used; third refused.
- Simultaneous player and enemy requests with one free slot (slot 3) -> player gets slot 3; enemy refused. With PROJECTILE_PENDING_EN, enemy is served on the cycle after slot 3 frees.
- endLevel with all four slots flying and a coincident player request -> all outputs 0 next cycle; no accept; no shotDropped.

Source files
------------

// File: rtl/projectile_pool_fsm_if.sv
// Shooter-side bus for projectile_pool_fsm: requests, pool status and per-slot outputs.
interface projectile_pool_fsm_if #(
  parameter int NUM_SLOTS = 4
);
  logic                   startOfFrame;
  logic                   shootRequestPlayer;
  logic                   shootRequestEnemy;
  logic [NUM_SLOTS-1:0]   projectileEnd;
  logic [3:0]             level;
  logic                   endLevel;
  logic                   speedPowerup;
  logic [NUM_SLOTS-1:0]   visible;
  logic [NUM_SLOTS-1:0]   loadCoordinates;
  logic [NUM_SLOTS*12-1:0] speed;
  logic [NUM_SLOTS-1:0]   beingShot;
  logic                   playerAccept;
  logic                   enemyAccept;
  logic                   shotDropped;

  modport master (
    output startOfFrame, shootRequestPlayer, shootRequestEnemy, projectileEnd,
           level, endLevel, speedPowerup,
    input  visible, loadCoordinates, speed, beingShot,
           playerAccept, enemyAccept, shotDropped
  );

  modport slave (
    input  startOfFrame, shootRequestPlayer, shootRequestEnemy, projectileEnd,
           level, endLevel, speedPowerup,
    output visible, loadCoordinates, speed, beingShot,
           playerAccept, enemyAccept, shotDropped
  );
endinterface

// File: rtl/projectile_pool_fsm.sv
// Pool of NUM_SLOTS projectile slots shared by player and enemy shooters.
// Each slot runs IDLE -> LOAD_x -> FLY_x -> IDLE; requests get the lowest free slot,
// player first. Player rate is limited by a per-frame cooldown, enemy by an in-flight cap.
// Optional macro PROJECTILE_PENDING_EN: one-deep per-source pending request that is
// retried when a slot frees instead of being dropped.
module projectile_pool_fsm #(
  parameter int NUM_SLOTS                       = 4,
  parameter int MAX_ENEMY_IN_FLIGHT             = 2,
  parameter int PLAYER_COOLDOWN_FRAMES          = 6,
  parameter int ENEMY_PROJECTILE_BASE_SPEED     = 130,
  parameter int PLAYER_PROJECTILE_BASE_SPEED    = 300,
  parameter int LEVEL_SPEED_MODIFIER            = 10,
  parameter int PLAYER_PROJECTILE_POWERUP_SPEED = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  projectile_pool_fsm_if.slave  bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_P = 3'd1;
  localparam logic [2:0] ST_LOAD_E = 3'd2;
  localparam logic [2:0] ST_FLY_P  = 3'd3;
  localparam logic [2:0] ST_FLY_E  = 3'd4;

  localparam logic [NUM_SLOTS-1:0] ONE = NUM_SLOTS'(1);
  localparam logic [3:0]  COOLDOWN_LOAD = 4'(PLAYER_COOLDOWN_FRAMES);
  localparam logic [3:0]  ENEMY_CAP     = 4'(MAX_ENEMY_IN_FLIGHT);
  localparam logic [11:0] P_SPEED_BASE  = 12'(-PLAYER_PROJECTILE_BASE_SPEED);
  localparam logic [11:0] P_SPEED_BOOST =
    12'(-(PLAYER_PROJECTILE_BASE_SPEED + PLAYER_PROJECTILE_POWERUP_SPEED));
  localparam logic [11:0] E_SPEED_BASE  = 12'(ENEMY_PROJECTILE_BASE_SPEED);
  localparam logic [11:0] E_SPEED_STEP  = 12'(LEVEL_SPEED_MODIFIER);

  logic [NUM_SLOTS-1:0] free_mask, enemy_mask;
  logic [NUM_SLOTS-1:0] p_grant, e_free, e_grant;
  logic [3:0]           enemy_count;
  logic                 p_req, e_req, p_gate, e_gate, p_ok, e_ok, p_drop, e_drop;
  logic [3:0]           cool_q, cool_d;
  logic                 p_acc_q, e_acc_q, drop_q;
  logic [11:0]          player_speed, enemy_speed;
`ifdef PROJECTILE_PENDING_EN
  logic                 pend_p_q, pend_p_d, pend_e_q, pend_e_d;
`endif

  assign player_speed = bus.speedPowerup ? P_SPEED_BOOST : P_SPEED_BASE;
  assign enemy_speed  = E_SPEED_BASE + E_SPEED_STEP * {8'd0, bus.level};

  // Per-slot state machine and its combinational outputs.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [2:0] st_q, st_d;

      assign free_mask[gi]  = (st_q == ST_IDLE);
      assign enemy_mask[gi] = (st_q == ST_LOAD_E) || (st_q == ST_FLY_E);
      assign bus.loadCoordinates[gi] = (st_q == ST_LOAD_P) || (st_q == ST_LOAD_E);
      assign bus.visible[gi]   = (st_q == ST_FLY_P) || (st_q == ST_FLY_E);
      assign bus.beingShot[gi] = (st_q != ST_IDLE);
      assign bus.speed[12*gi +: 12] = (st_q == ST_FLY_P) ? player_speed :
                                      (st_q == ST_FLY_E) ? enemy_speed  : 12'd0;

      // Next slot state: endLevel flushes; end of flight only counts while flying.
      always_comb begin
        st_d = st_q;
        if (bus.endLevel) begin
          st_d = ST_IDLE;
        end else begin
          case (st_q)
            ST_IDLE: begin
              if (p_ok && p_grant[gi])      st_d = ST_LOAD_P;
              else if (e_ok && e_grant[gi]) st_d = ST_LOAD_E;
            end
            ST_LOAD_P: st_d = ST_FLY_P;
            ST_LOAD_E: st_d = ST_FLY_E;
            ST_FLY_P, ST_FLY_E: if (bus.projectileEnd[gi]) st_d = ST_IDLE;
            default:   st_d = ST_IDLE;
          endcase
        end
      end

      // Slot state register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) st_q <= ST_IDLE;
        else       st_q <= st_d;
      end
    end
  endgenerate

  // Count slots currently owned by the enemy (loading or flying).
  always_comb begin
    enemy_count = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) enemy_count = enemy_count + {3'd0, enemy_mask[i]};
  end

  // Allocation: player gets the lowest free slot, enemy the lowest of what remains.
  always_comb begin
`ifdef PROJECTILE_PENDING_EN
    p_req = bus.shootRequestPlayer | pend_p_q;
    e_req = bus.shootRequestEnemy  | pend_e_q;
`else
    p_req = bus.shootRequestPlayer;
    e_req = bus.shootRequestEnemy;
`endif
    p_gate  = (cool_q == 4'd0);
    e_gate  = (enemy_count < ENEMY_CAP);
    p_grant = free_mask & (~free_mask + ONE);
    p_ok    = !bus.endLevel && p_req && p_gate && (|free_mask);
    e_free  = free_mask & ~(p_ok ? p_grant : '0);
    e_grant = e_free & (~e_free + ONE);
    e_ok    = !bus.endLevel && e_req && e_gate && (|e_free);
  end

  // Refusal handling: drop pulses, and pending capture when only a slot was missing.
  always_comb begin
    p_drop = 1'b0;
    e_drop = 1'b0;
`ifdef PROJECTILE_PENDING_EN
    pend_p_d = pend_p_q;
    pend_e_d = pend_e_q;
    if (bus.endLevel) begin
      pend_p_d = 1'b0;
      pend_e_d = 1'b0;
    end else begin
      // A new request arriving while the pending one is served has nowhere to go.
      if (p_ok) begin
        pend_p_d = 1'b0;
        p_drop   = pend_p_q && bus.shootRequestPlayer;
      end else if (bus.shootRequestPlayer) begin
        if (p_gate && !(|free_mask) && !pend_p_q) pend_p_d = 1'b1;
        else                                      p_drop   = 1'b1;
      end
      if (e_ok) begin
        pend_e_d = 1'b0;
        e_drop   = pend_e_q && bus.shootRequestEnemy;
      end else if (bus.shootRequestEnemy) begin
        if (e_gate && !(|e_free) && !pend_e_q) pend_e_d = 1'b1;
        else                                   e_drop   = 1'b1;
      end
    end
`else
    p_drop = !bus.endLevel && bus.shootRequestPlayer && !p_ok;
    e_drop = !bus.endLevel && bus.shootRequestEnemy  && !e_ok;
`endif
  end

  // Player cooldown: reload on accept, count down per frame, cleared by endLevel.
  always_comb begin
    cool_d = cool_q;
    if (bus.endLevel)                            cool_d = 4'd0;
    else if (p_ok)                               cool_d = COOLDOWN_LOAD;
    else if (bus.startOfFrame && cool_q != 4'd0) cool_d = cool_q - 4'd1;
  end

  // Registered status pulses, cooldown and pending flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cool_q  <= 4'd0;
      p_acc_q <= 1'b0;
      e_acc_q <= 1'b0;
      drop_q  <= 1'b0;
`ifdef PROJECTILE_PENDING_EN
      pend_p_q <= 1'b0;
      pend_e_q <= 1'b0;
`endif
    end else begin
      cool_q  <= cool_d;
      p_acc_q <= p_ok;
      e_acc_q <= e_ok;
      drop_q  <= p_drop | e_drop;
`ifdef PROJECTILE_PENDING_EN
      pend_p_q <= pend_p_d;
      pend_e_q <= pend_e_d;
`endif
    end
  end

  assign bus.playerAccept = p_acc_q;
  assign bus.enemyAccept  = e_acc_q;
  assign bus.shotDropped  = drop_q;

endmodule

// File: tb/tb_projectile_pool_fsm.sv
// Directed bench for projectile_pool_fsm: a vector table for single-cycle behaviour
// plus hand-written sequences for the one-free-slot race and the endLevel flush.
module tb_projectile_pool_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  projectile_pool_fsm_if #(.NUM_SLOTS(4)) bus ();

  projectile_pool_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int p, e, pe, el, sof, pu, lvl;
    int x_load, x_vis, x_busy, x_pa, x_ea, x_dr, x_s0, x_s1;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic p, input logic e, input logic [3:0] pe,
                       input logic el, input logic sof);
    bus.shootRequestPlayer = p;
    bus.shootRequestEnemy  = e;
    bus.projectileEnd      = pe;
    bus.endLevel           = el;
    bus.startOfFrame       = sof;
    @(posedge clk);
    #1;
    bus.shootRequestPlayer = 1'b0;
    bus.shootRequestEnemy  = 1'b0;
    bus.projectileEnd      = 4'd0;
    bus.endLevel           = 1'b0;
    bus.startOfFrame       = 1'b0;
  endtask

  function automatic int spd(input int i);
    logic [11:0] s;
    s = bus.speed[12*i +: 12];
    return int'($signed(s));
  endfunction

  task automatic check_all(input string tag, input int ld, input int vis, input int busy,
                           input int pa, input int ea, input int dr, input int s0, input int s1);
    chk({tag, " load"},  int'(bus.loadCoordinates), ld);
    chk({tag, " vis"},   int'(bus.visible), vis);
    chk({tag, " busy"},  int'(bus.beingShot), busy);
    chk({tag, " pacc"},  int'(bus.playerAccept), pa);
    chk({tag, " eacc"},  int'(bus.enemyAccept), ea);
    chk({tag, " drop"},  int'(bus.shotDropped), dr);
    chk({tag, " spd0"},  spd(0), s0);
    chk({tag, " spd1"},  spd(1), s1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         p  e  pe el sof pu lvl | load vis busy pa ea dr  s0    s1
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,  'h1, 'h0, 'h1, 1, 0, 0, 0,    0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,  'h0, 'h1, 'h1, 0, 0, 0, -300, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0,  'h0, 'h1, 'h1, 0, 0, 0, -500, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 15, 'h2, 'h1, 'h3, 0, 1, 0, -300, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 15, 'h0, 'h3, 'h3, 0, 0, 0, -300, 280};
    tbl[5]  = '{0, 0, 2, 0, 0, 0, 15, 'h0, 'h1, 'h1, 0, 0, 0, -300, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 15, 'h0, 'h1, 'h1, 0, 0, 1, -300, 0};
    for (int i = 7; i <= 11; i++)
      tbl[i] = '{0, 0, 0, 0, 1, 0, 15, 'h0, 'h1, 'h1, 0, 0, 0, -300, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 15, 'h0, 'h1, 'h1, 0, 0, 1, -300, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 0, 15, 'h0, 'h1, 'h1, 0, 0, 0, -300, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 15, 'h2, 'h1, 'h3, 1, 0, 0, -300, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 15, 'h0, 'h3, 'h3, 0, 0, 0, -300, -300};
    tbl[16] = '{1, 1, 0, 1, 0, 0, 15, 'h0, 'h0, 'h0, 0, 0, 0, 0,    0};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 15, 'h1, 'h0, 'h1, 1, 0, 0, 0,    0};
    tbl[18] = '{0, 0, 0, 1, 0, 0, 15, 'h0, 'h0, 'h0, 0, 0, 0, 0,    0};
    tbl[19] = '{0, 1, 0, 0, 0, 0, 15, 'h1, 'h0, 'h1, 0, 1, 0, 0,    0};
    tbl[20] = '{0, 1, 0, 0, 0, 0, 15, 'h2, 'h1, 'h3, 0, 1, 0, 280,  0};
    tbl[21] = '{0, 1, 0, 0, 0, 0, 15, 'h0, 'h3, 'h3, 0, 0, 1, 280,  280};
    tbl[22] = '{0, 1, 1, 0, 0, 0, 15, 'h0, 'h2, 'h2, 0, 0, 1, 0,    280};
    tbl[23] = '{0, 1, 1, 0, 0, 0, 15, 'h1, 'h2, 'h3, 0, 1, 0, 0,    280};
    tbl[24] = '{0, 0, 1, 0, 0, 0, 15, 'h0, 'h3, 'h3, 0, 0, 0, 280,  280};

    bus.shootRequestPlayer = 1'b0;
    bus.shootRequestEnemy  = 1'b0;
    bus.projectileEnd      = 4'd0;
    bus.endLevel           = 1'b0;
    bus.startOfFrame       = 1'b0;
    bus.level              = 4'd0;
    bus.speedPowerup       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    pulse(0, 0, 4'd0, 0, 0);
    chk("post-reset busy", int'(bus.beingShot), 0);
    $display("txn reset: busy=%b", bus.beingShot);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 25; i++) begin
      bus.level        = 4'(tbl[i].lvl);
      bus.speedPowerup = 1'(tbl[i].pu);
      pulse(1'(tbl[i].p), 1'(tbl[i].e), 4'(tbl[i].pe), 1'(tbl[i].el), 1'(tbl[i].sof));
      $display("txn row%0d: load=%b vis=%b busy=%b pa=%b ea=%b drop=%b s0=%0d s1=%0d",
               i, bus.loadCoordinates, bus.visible, bus.beingShot, bus.playerAccept,
               bus.enemyAccept, bus.shotDropped, spd(0), spd(1));
      check_all($sformatf("row%0d", i), tbl[i].x_load, tbl[i].x_vis, tbl[i].x_busy,
                tbl[i].x_pa, tbl[i].x_ea, tbl[i].x_dr, tbl[i].x_s0, tbl[i].x_s1);
    end

    // One free slot: fill slots 0..2, then player and enemy request together
    pulse(0, 0, 4'd0, 1, 0);
    pulse(1, 0, 4'd0, 0, 0);
    pulse(0, 1, 4'd0, 0, 0);
    repeat (6) pulse(0, 0, 4'd0, 0, 1);
    pulse(1, 0, 4'd0, 0, 0);
    chk("fill slot2 load", int'(bus.loadCoordinates), 'h4);
    repeat (6) pulse(0, 0, 4'd0, 0, 1);
    pulse(1, 1, 4'd0, 0, 0);
    $display("txn race: load=%b pa=%b ea=%b drop=%b", bus.loadCoordinates,
             bus.playerAccept, bus.enemyAccept, bus.shotDropped);
    chk("race load", int'(bus.loadCoordinates), 'h8);
    chk("race pacc", int'(bus.playerAccept), 1);
    chk("race eacc", int'(bus.enemyAccept), 0);
    chk("race busy", int'(bus.beingShot), 'hF);
`ifdef PROJECTILE_PENDING_EN
    chk("race drop", int'(bus.shotDropped), 0);
`else
    chk("race drop", int'(bus.shotDropped), 1);
`endif
    pulse(0, 0, 4'd0, 0, 0);
    chk("race all flying", int'(bus.visible), 'hF);
    pulse(0, 0, 4'h8, 0, 0);
    $display("txn free3: busy=%b ea=%b", bus.beingShot, bus.enemyAccept);
    chk("free3 busy", int'(bus.beingShot), 'h7);
    chk("free3 eacc", int'(bus.enemyAccept), 0);
    pulse(0, 0, 4'd0, 0, 0);
`ifdef PROJECTILE_PENDING_EN
    chk("pending served eacc", int'(bus.enemyAccept), 1);
    chk("pending served load", int'(bus.loadCoordinates), 'h8);
    pulse(0, 0, 4'd0, 0, 0);
`else
    chk("no pending eacc", int'(bus.enemyAccept), 0);
    chk("no pending busy", int'(bus.beingShot), 'h7);
    pulse(0, 1, 4'd0, 0, 0);
    chk("refill eacc", int'(bus.enemyAccept), 1);
    pulse(0, 0, 4'd0, 0, 0);
`endif
    chk("four flying", int'(bus.visible), 'hF);

    // endLevel with all slots flying and coincident requests
    pulse(1, 1, 4'd0, 1, 0);
    $display("txn endLevel: vis=%b busy=%b pa=%b ea=%b drop=%b", bus.visible,
             bus.beingShot, bus.playerAccept, bus.enemyAccept, bus.shotDropped);
    check_all("endlevel", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("endlevel spd2", spd(2), 0);
    chk("endlevel spd3", spd(3), 0);
    pulse(0, 0, 4'd0, 0, 0);
    chk("after endlevel busy", int'(bus.beingShot), 0);
    chk("after endlevel pacc", int'(bus.playerAccept), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
